// File: rtl/system_halt_pkg.sv
// Shared definitions for the halt-register poller.
// Holds the poller FSM state encoding and the default parameter values
// used by system_halt_poller.
package system_halt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // polling disabled, bus idle
        ST_REQ  = 2'd1,  // read request on the bus, held through waitrequest
        ST_LAT  = 2'd2,  // request accepted, waiting out the read latency
        ST_WAIT = 2'd3   // idle gap before the next poll
    } state_t;

    localparam int DEF_POLL_INTERVAL  = 1000;
    localparam int DEF_READ_LATENCY   = 1;
    localparam int DEF_POLL_ADDR      = 0;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage : system_halt_pkg

// File: rtl/halt_edge_detect.sv
// Registered level and edge detector for the sampled halt bit.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   sample_valid  - strobe: sample_bit is valid this cycle
//   sample_bit    - halt bit read from the slave
//   level         - last sampled value (0 after reset)
//   rise, fall    - one-cycle pulses, registered with level, on a change
module halt_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sample_valid,
    input  logic sample_bit,
    output logic level,
    output logic rise,
    output logic fall
);

    logic level_q, level_d;
    logic rise_q,  rise_d;
    logic fall_q,  fall_d;

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample_valid) begin
            level_d = sample_bit;
            rise_d  =  sample_bit & ~level_q;
            fall_d  = ~sample_bit &  level_q;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule : halt_edge_detect

// File: rtl/system_halt_poller.sv
// Periodically reads a halt bit from an Avalon-MM slave and reports its
// level, its edges, the number of completed reads and a sticky stall timeout.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   enable            - polling enable
//   avm_address       - read address (constant POLL_ADDR)
//   avm_read          - read request, held while avm_waitrequest is high
//   avm_waitrequest   - slave stall
//   avm_readdata      - slave read data, bit 0 is the halt bit
//   halt_level        - last sampled halt bit
//   halt_rise/fall    - one-cycle pulses on a 0->1 / 1->0 change
//   poll_count        - completed-read count, wraps at 16 bits
//   timeout_err       - sticky: a request stalled TIMEOUT_CYCLES cycles
module system_halt_poller
    import system_halt_pkg::*;
#(
    parameter int POLL_INTERVAL  = DEF_POLL_INTERVAL,
    parameter int READ_LATENCY   = DEF_READ_LATENCY,
    parameter int POLL_ADDR      = DEF_POLL_ADDR,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        halt_level,
    output logic        halt_rise,
    output logic        halt_fall,
    output logic [15:0] poll_count,
    output logic        timeout_err
);

    localparam logic [31:0] WAIT_LAST = 32'(POLL_INTERVAL - 1);
    localparam logic [31:0] LAT_LOAD  = 32'(READ_LATENCY);
    localparam logic [31:0] STALL_MAX = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] lat_cnt_q, lat_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] poll_count_q, poll_count_d;
    logic        timeout_err_q, timeout_err_d;
    logic        sample_valid;

    // The latency counter is loaded with READ_LATENCY on accept; the cycle it
    // reads 1 is exactly READ_LATENCY cycles after the accept cycle.
    assign sample_valid = (state_q == ST_LAT) && (lat_cnt_q == 32'd1);

    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        timeout_err_d = timeout_err_q;
        poll_count_d  = poll_count_q + {15'd0, sample_valid};

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_REQ;
            end
            ST_REQ: begin
                // enable is ignored here: an issued request always completes.
                if (avm_waitrequest) begin
                    if (stall_cnt_q != STALL_MAX) stall_cnt_d = stall_cnt_q + 32'd1;
                    if (stall_cnt_d == STALL_MAX) timeout_err_d = 1'b1;
                end else begin
                    stall_cnt_d = 32'd0;
                    lat_cnt_d   = LAT_LOAD;
                    state_d     = ST_LAT;
                end
            end
            ST_LAT: begin
                if (sample_valid) begin
                    lat_cnt_d  = 32'd0;
                    wait_cnt_d = 32'd0;
                    state_d    = enable ? ST_WAIT : ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 32'd1;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    wait_cnt_d = 32'd0;
                    state_d    = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 32'd0;
                    state_d    = ST_REQ;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lat_cnt_q     <= 32'd0;
            wait_cnt_q    <= 32'd0;
            stall_cnt_q   <= 32'd0;
            poll_count_q  <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            poll_count_q  <= poll_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    halt_edge_detect u_edge (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_bit   (avm_readdata[0]),
        .level        (halt_level),
        .rise         (halt_rise),
        .fall         (halt_fall)
    );

    // Only bit 0 of the read data carries the halt flag.
    logic unused_readdata_hi;
    assign unused_readdata_hi = ^avm_readdata[31:1];

    assign avm_address = 2'(POLL_ADDR);
    assign avm_read    = (state_q == ST_REQ);
    assign poll_count  = poll_count_q;
    assign timeout_err = timeout_err_q;

endmodule : system_halt_poller

// File: tb/tb_system_halt_poller.sv
// Directed bench: one default-parameter poller plus a fast poller
// (POLL_INTERVAL=1, READ_LATENCY=2, POLL_ADDR=2, TIMEOUT_CYCLES=4).
module tb_system_halt_poller;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [1:0]  avm_address;
    logic        avm_read, halt_level, halt_rise, halt_fall, timeout_err;
    logic [15:0] poll_count;

    logic        f_enable, f_waitrequest;
    logic [31:0] f_readdata;
    logic [1:0]  f_address;
    logic        f_read, f_level, f_rise, f_fall, f_err;
    logic [15:0] f_count;

    int checks   = 0;
    int failures = 0;

    system_halt_poller dut (
        .clk(clk), .reset(reset), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .halt_level(halt_level), .halt_rise(halt_rise), .halt_fall(halt_fall),
        .poll_count(poll_count), .timeout_err(timeout_err)
    );

    system_halt_poller #(
        .POLL_INTERVAL(1), .READ_LATENCY(2), .POLL_ADDR(2), .TIMEOUT_CYCLES(4)
    ) dut_fast (
        .clk(clk), .reset(reset), .enable(f_enable),
        .avm_address(f_address), .avm_read(f_read),
        .avm_waitrequest(f_waitrequest), .avm_readdata(f_readdata),
        .halt_level(f_level), .halt_rise(f_rise), .halt_fall(f_fall),
        .poll_count(f_count), .timeout_err(f_err)
    );

    // Inputs are driven and outputs observed 1 time unit after the edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_main_read(input string name, input int budget);
        int i;
        i = 0;
        while (!avm_read && i < budget) begin
            step();
            i++;
        end
        checks++;
        if (avm_read !== 1'b1) begin
            failures++;
            $display("FAIL %s: no avm_read within %0d cycles (got %b, want 1)", name, budget, avm_read);
        end
    endtask

    task automatic wait_fast_read(input string name, input int budget);
        int i;
        i = 0;
        while (!f_read && i < budget) begin
            step();
            i++;
        end
        checks++;
        if (f_read !== 1'b1) begin
            failures++;
            $display("FAIL %s: no fast avm_read within %0d cycles (got %b, want 1)", name, budget, f_read);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; avm_waitrequest = 1'b0; avm_readdata = 32'd0;
        f_enable = 1'b0; f_waitrequest = 1'b0; f_readdata = 32'd0;
        step(3);
        checks++;
        if ({avm_read, halt_level, halt_rise, halt_fall, timeout_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000", {avm_read, halt_level, halt_rise, halt_fall, timeout_err});
        end
        checks++;
        if (poll_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_count: got %h want 0000", poll_count);
        end
        checks++;
        if (avm_address !== 2'd0 || f_address !== 2'd2) begin
            failures++;
            $display("FAIL reset_address: got %0d/%0d want 0/2", avm_address, f_address);
        end
        reset = 1'b0;
        step(2);
        checks++;
        if (avm_read !== 1'b0 || f_read !== 1'b0) begin
            failures++;
            $display("FAIL idle_disabled: got read %b/%b want 0/0", avm_read, f_read);
        end
    endtask

    task automatic test_basic_poll();
        int gap;
        enable = 1'b1;
        step();
        checks++;
        if (avm_read !== 1'b1) begin
            failures++;
            $display("FAIL basic_req: got avm_read %b want 1", avm_read);
        end
        step();
        checks++;
        if (avm_read !== 1'b0) begin
            failures++;
            $display("FAIL basic_read_width: got avm_read %b want 0", avm_read);
        end
        step();
        checks++;
        if ({halt_level, halt_rise, halt_fall} !== 3'b000 || poll_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_update: got lvl/rise/fall %b count %0d want 000 count 1",
                     {halt_level, halt_rise, halt_fall}, poll_count);
        end
        avm_readdata = 32'h0000_0001;
        gap = 0;
        while (!avm_read && gap < 2000) begin
            step();
            gap++;
        end
        checks++;
        if (gap !== 1000) begin
            failures++;
            $display("FAIL basic_interval: got %0d cycles from update to next read, want 1000", gap);
        end
    endtask

    task automatic test_rise();
        step();
        checks++;
        if (halt_rise !== 1'b0 || halt_level !== 1'b0) begin
            failures++;
            $display("FAIL rise_early: got rise %b level %b want 0 0", halt_rise, halt_level);
        end
        step();
        checks++;
        if (halt_rise !== 1'b1 || halt_fall !== 1'b0 || halt_level !== 1'b1 || poll_count !== 16'd2) begin
            failures++;
            $display("FAIL rise_pulse: got rise %b fall %b level %b count %0d want 1 0 1 2",
                     halt_rise, halt_fall, halt_level, poll_count);
        end
        step();
        checks++;
        if (halt_rise !== 1'b0 || halt_level !== 1'b1) begin
            failures++;
            $display("FAIL rise_width: got rise %b level %b want 0 1", halt_rise, halt_level);
        end
    endtask

    task automatic test_fall();
        avm_readdata = 32'hFFFF_FFFE;
        wait_main_read("fall_wait", 1100);
        step(2);
        checks++;
        if (halt_fall !== 1'b1 || halt_rise !== 1'b0 || halt_level !== 1'b0 || poll_count !== 16'd3) begin
            failures++;
            $display("FAIL fall_pulse: got fall %b rise %b level %b count %0d want 1 0 0 3",
                     halt_fall, halt_rise, halt_level, poll_count);
        end
        step();
        checks++;
        if (halt_fall !== 1'b0) begin
            failures++;
            $display("FAIL fall_width: got fall %b want 0", halt_fall);
        end
    endtask

    task automatic test_wait_10();
        int high;
        avm_waitrequest = 1'b1;
        wait_main_read("stall10_wait", 1100);
        high = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (avm_read === 1'b1 && avm_address === 2'd0) high++;
        end
        avm_waitrequest = 1'b0;
        step();
        checks++;
        if (high !== 11 || avm_read !== 1'b0) begin
            failures++;
            $display("FAIL stall10_hold: got %0d stable request cycles (read now %b) want 11 (read 0)", high, avm_read);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL stall10_no_timeout: got %b want 0", timeout_err);
        end
        step(6);
        checks++;
        if (poll_count !== 16'd4) begin
            failures++;
            $display("FAIL stall10_one_accept: got count %0d want 4", poll_count);
        end
    endtask

    task automatic test_timeout();
        int high;
        avm_waitrequest = 1'b1;
        wait_main_read("timeout_wait", 1100);
        step(254);
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: got %b after 254 stall cycles want 0", timeout_err);
        end
        step();
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set: got %b after 255 stall cycles want 1", timeout_err);
        end
        high = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (avm_read === 1'b1) high++;
        end
        checks++;
        if (high !== 45) begin
            failures++;
            $display("FAIL timeout_request_held: got %0d of 45 cycles with avm_read want 45", high);
        end
        avm_waitrequest = 1'b0;
        step(2);
        checks++;
        if (poll_count !== 16'd5) begin
            failures++;
            $display("FAIL timeout_completes: got count %0d want 5", poll_count);
        end
        step(10);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got %b want 1", timeout_err);
        end
    endtask

    task automatic test_enable_drop_lat();
        int reads;
        avm_readdata = 32'd1;
        wait_main_read("drop_wait", 1100);
        step();
        enable = 1'b0;
        step();
        checks++;
        if (poll_count !== 16'd6 || halt_level !== 1'b1 || halt_rise !== 1'b1) begin
            failures++;
            $display("FAIL drop_sample: got count %0d level %b rise %b want 6 1 1", poll_count, halt_level, halt_rise);
        end
        reads = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (avm_read !== 1'b0) reads++;
        end
        checks++;
        if (reads !== 0 || poll_count !== 16'd6) begin
            failures++;
            $display("FAIL drop_idle: got %0d read cycles count %0d want 0 reads count 6", reads, poll_count);
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1; avm_waitrequest = 1'b1;
        wait_main_read("rst_req_wait", 4);
        reset = 1'b1;
        step();
        checks++;
        if (avm_read !== 1'b0 || poll_count !== 16'd0 || timeout_err !== 1'b0 || halt_level !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_req: got read %b count %0d err %b level %b want 0 0 0 0",
                     avm_read, poll_count, timeout_err, halt_level);
        end
        reset = 1'b0; avm_waitrequest = 1'b0; avm_readdata = 32'd1;
        wait_main_read("rst_lat_wait", 4);
        step();
        reset = 1'b1; enable = 1'b0;
        step();
        reset = 1'b0;
        step(3);
        checks++;
        if (poll_count !== 16'd0 || halt_level !== 1'b0 || halt_rise !== 1'b0 || avm_read !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_lat_discard: got count %0d level %b rise %b read %b want 0 0 0 0",
                     poll_count, halt_level, halt_rise, avm_read);
        end
        enable = 1'b1;
        wait_main_read("first_wait", 4);
        step(2);
        checks++;
        if (halt_rise !== 1'b1 || halt_level !== 1'b1 || poll_count !== 16'd1) begin
            failures++;
            $display("FAIL first_sample_rise: got rise %b level %b count %0d want 1 1 1", halt_rise, halt_level, poll_count);
        end
        enable = 1'b0;
    endtask

    task automatic test_fast_latency();
        f_readdata = 32'd1; f_waitrequest = 1'b0; f_enable = 1'b1;
        wait_fast_read("fast_wait", 4);
        step(2);
        checks++;
        if (f_level !== 1'b0 || f_rise !== 1'b0 || f_read !== 1'b0) begin
            failures++;
            $display("FAIL fast_latency_early: got level %b rise %b read %b want 0 0 0", f_level, f_rise, f_read);
        end
        step();
        checks++;
        if (f_rise !== 1'b1 || f_level !== 1'b1 || f_count !== 16'd1) begin
            failures++;
            $display("FAIL fast_latency_rise: got rise %b level %b count %0d want 1 1 1", f_rise, f_level, f_count);
        end
        step();
        checks++;
        if (f_read !== 1'b1 || f_rise !== 1'b0) begin
            failures++;
            $display("FAIL fast_interval: got read %b rise %b want 1 0", f_read, f_rise);
        end
    endtask

    task automatic test_fast_drop_req();
        int reads;
        f_waitrequest = 1'b1; f_enable = 1'b0;
        step(3);
        checks++;
        if (f_err !== 1'b0 || f_read !== 1'b1) begin
            failures++;
            $display("FAIL fast_timeout_early: got err %b read %b want 0 1", f_err, f_read);
        end
        step();
        checks++;
        if (f_err !== 1'b1 || f_read !== 1'b1) begin
            failures++;
            $display("FAIL fast_timeout_set: got err %b read %b want 1 1", f_err, f_read);
        end
        f_waitrequest = 1'b0;
        step(3);
        checks++;
        if (f_count !== 16'd2 || f_level !== 1'b1 || f_rise !== 1'b0) begin
            failures++;
            $display("FAIL fast_drop_req_completes: got count %0d level %b rise %b want 2 1 0", f_count, f_level, f_rise);
        end
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (f_read !== 1'b0) reads++;
        end
        checks++;
        if (reads !== 0) begin
            failures++;
            $display("FAIL fast_drop_req_idle: got %0d read cycles want 0", reads);
        end
    endtask

    task automatic test_wrap();
        force dut_fast.poll_count_q = 16'hFFFD;
        step();
        release dut_fast.poll_count_q;
        f_enable = 1'b1;
        step(12);
        checks++;
        if (f_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero: got %h want 0000", f_count);
        end
        step(4);
        checks++;
        if (f_count !== 16'h0001) begin
            failures++;
            $display("FAIL wrap_one: got %h want 0001", f_count);
        end
        f_enable = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_poll();
        test_rise();
        test_fall();
        test_wait_10();
        test_timeout();
        test_enable_drop_lat();
        test_reset_mid();
        test_fast_latency();
        test_fast_drop_req();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_system_halt_poller

// File: doc/system_halt_poller.md
SYSTEM_HALT_POLLER -- requirements
Module: system_halt_poller

Interface
REQ-001 The block SHALL have parameter POLL_INTERVAL, default 1000, meaning idle cycles between the end of one read and the next request (minimum 1).
REQ-002 The block SHALL have parameter READ_LATENCY, default 1, meaning fixed slave read latency in cycles (minimum 1).
REQ-003 The block SHALL have parameter POLL_ADDR, default 0, meaning the 2-bit word address polled.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning waitrequest-stall cycles before the error flag sets.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port enable, input, 1 bit: polling enable.
REQ-008 The block SHALL have port avm_address, output, 2 bits: read address, always POLL_ADDR.
REQ-009 The block SHALL have port avm_read, output, 1 bit: read request.
REQ-010 The block SHALL have port avm_waitrequest, input, 1 bit: slave stall.
REQ-011 The block SHALL have port avm_readdata, input, 32 bits: slave read data; only bit 0 is used.
REQ-012 The block SHALL have port halt_level, output, 1 bit: last sampled halt bit.
REQ-013 The block SHALL have port halt_rise, output, 1 bit: one-cycle pulse on a 0->1 change.
REQ-014 The block SHALL have port halt_fall, output, 1 bit: one-cycle pulse on a 1->0 change.
REQ-015 The block SHALL have port poll_count, output, 16 bits: completed-read count.
REQ-016 The block SHALL have port timeout_err, output, 1 bit: sticky stall-timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, LAT and WAIT.
REQ-018 IDLE: avm_read=0; enable=1 -> REQ on the next cycle.
REQ-019 REQ: avm_read=1, and the request SHALL be held unchanged while avm_waitrequest=1.
REQ-020 A read SHALL be accepted in the cycle where avm_read=1 and avm_waitrequest=0; the FSM then enters LAT with a latency counter loaded to READ_LATENCY.
REQ-021 LAT: avm_read=0; avm_readdata[0] SHALL be sampled exactly READ_LATENCY cycles after the accept cycle, and the FSM then enters WAIT.
REQ-022 halt_level SHALL update on the cycle after sampling, and halt_rise/halt_fall SHALL pulse in that same cycle, based on the comparison with the previous halt_level.
REQ-023 poll_count SHALL increment in the same cycle as the halt_level update and wrap from 16'hFFFF to 0.
REQ-024 WAIT: the FSM SHALL count POLL_INTERVAL cycles, then enter REQ if enable=1, else IDLE.
REQ-025 Deasserting enable during REQ or LAT SHALL NOT abort the transaction; the transaction SHALL complete, including the sample and update, before the FSM goes to IDLE.
REQ-026 Deasserting enable in WAIT SHALL cause an immediate transition to IDLE on the next cycle.
REQ-027 A stall counter SHALL count consecutive REQ cycles with avm_waitrequest=1; timeout_err SHALL set when the count reaches TIMEOUT_CYCLES, and the request SHALL remain asserted.
REQ-028 timeout_err SHALL clear only on reset.
REQ-029 The stall counter SHALL saturate and clear on accept.
REQ-030 halt_rise and halt_fall SHALL never be asserted in the same cycle.

Reset
REQ-031 When reset=1 on a clock edge: state=IDLE, avm_read=0, halt_level=0, halt_rise=0, halt_fall=0, poll_count=0, timeout_err=0, and all counters=0.
REQ-032 Reset mid-transaction SHALL drop avm_read on the next cycle and discard any pending sample.
REQ-033 The first sample after reset SHALL compare against halt_level=0, so a halted slave yields halt_rise.

Structure
REQ-034 The FSM state encoding and the default parameter values SHALL live in the shared package system_halt_pkg.
REQ-035 Edge detection SHALL be a sub-module, halt_edge_detect (inputs: sample strobe, bit; outputs: level, rise, fall).

Verification
REQ-036 Scenario: enable=1, slave readdata=0, no waitrequest -> avm_read is high for 1 cycle, halt_level=0, no pulses, poll_count=1, and the next avm_read occurs 1000 cycles after the sample.
REQ-037 Scenario: readdata bit0 goes 0->1 before the second poll -> halt_rise is high for exactly 1 cycle, READ_LATENCY+1 cycles after accept, and halt_level=1.
REQ-038 Scenario: waitrequest held for 10 cycles -> avm_read and avm_address are stable for 11 cycles, there is one accept, and timeout_err=0.
REQ-039 Scenario: waitrequest held for 300 cycles -> timeout_err=1 from cycle 255, the read still completes, and the flag stays set.
REQ-040 Scenario: enable drops during LAT -> the sample is taken, poll_count increments, the FSM reaches IDLE, and no further avm_read occurs.
REQ-041 Scenario: poll_count preloaded near wrap via 65537 polls with POLL_INTERVAL=1 -> the count reads 1.
